// File: rtl/issue_scoreboard.sv
// Register-dependency scoreboard and issue controller for the decode stage.
// Optional macro FORWARDING_EN: RAW stalls only on load-use; otherwise on any busy source.
module issue_scoreboard #(
   parameter int NUM_REGS     = 32,
   parameter int REG_ID_W     = 5,
   parameter int MAX_INFLIGHT = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                id_valid,
   input  logic [REG_ID_W-1:0] id_rs1,
   input  logic [REG_ID_W-1:0] id_rs2,
   input  logic                id_uses_rs1,
   input  logic                id_uses_rs2,
   input  logic [REG_ID_W-1:0] id_rd,
   input  logic                id_reg_write,
   input  logic                id_is_load,
   input  logic                wb_write_en,
   input  logic [REG_ID_W-1:0] wb_write_id,
   input  logic                kill_en,
   input  logic [REG_ID_W-1:0] kill_id,
   output logic                stall,
   output logic                issue,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                sb_error
);

   localparam int CW = $clog2(MAX_INFLIGHT + 1);

   logic [CW-1:0] cnt_q [NUM_REGS];
   logic [CW-1:0] cnt_d [NUM_REGS];
   logic          sb_error_q, sb_error_d;
   logic          track;
   logic          src1_used, src2_used;
   logic          raw, waw;

   assign src1_used = id_uses_rs1 && (id_rs1 != '0);
   assign src2_used = id_uses_rs2 && (id_rs2 != '0);
   assign waw       = id_reg_write && (id_rd != '0) && (cnt_q[id_rd] == CW'(MAX_INFLIGHT));

`ifdef FORWARDING_EN
   logic                ll_valid_q, ll_valid_d;
   logic [REG_ID_W-1:0] ll_rd_q, ll_rd_d;

   assign raw = ll_valid_q && ((src1_used && (id_rs1 == ll_rd_q)) ||
                               (src2_used && (id_rs2 == ll_rd_q)));

   always_comb begin
      ll_valid_d = ll_valid_q;
      ll_rd_d    = ll_rd_q;
      if (track && id_is_load) begin
         ll_valid_d = 1'b1;
         ll_rd_d    = id_rd;
      end else begin
         ll_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ll_valid_q <= 1'b0;
         ll_rd_q    <= '0;
      end else begin
         ll_valid_q <= ll_valid_d;
         ll_rd_q    <= ll_rd_d;
      end
   end

   // A kill of the held load cannot coincide with a new load issue keeping it, so the
   // unconditional reload above already clears last_load_valid in that cycle.
   logic unused_kill_fwd;
   assign unused_kill_fwd = kill_en;
`else
   assign raw = (src1_used && (cnt_q[id_rs1] != '0)) ||
                (src2_used && (cnt_q[id_rs2] != '0));

   logic unused_is_load;
   assign unused_is_load = id_is_load;
`endif

   assign stall = id_valid && (raw || waw);
   assign issue = id_valid && !stall;
   assign track = issue && id_reg_write && (id_rd != '0);

   always_comb begin
      int nxt;
      sb_error_d = sb_error_q;
      cnt_d[0]   = '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         nxt = int'(cnt_q[r]);
         if (track && (id_rd == REG_ID_W'(r)))             nxt = nxt + 1;
         if (wb_write_en && (wb_write_id == REG_ID_W'(r))) nxt = nxt - 1;
         if (kill_en && (kill_id == REG_ID_W'(r)))         nxt = nxt - 1;
         // Saturate at both ends and latch the error sticky.
         if (nxt < 0) begin
            nxt        = 0;
            sb_error_d = 1'b1;
         end else if (nxt > MAX_INFLIGHT) begin
            nxt        = MAX_INFLIGHT;
            sb_error_d = 1'b1;
         end
         cnt_d[r] = CW'(nxt);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
         sb_error_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
         sb_error_q <= sb_error_d;
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) busy_mask[r] = (cnt_q[r] != '0);
   end

   assign sb_error = sb_error_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard; forwarding-specific vectors
// are selected by FORWARDING_EN to match the DUT build.
module tb_issue_scoreboard;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
   logic        wb_write_en;
   logic [4:0]  wb_write_id;
   logic        kill_en;
   logic [4:0]  kill_id;
   logic        stall, issue, sb_error;
   logic [31:0] busy_mask;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   issue_scoreboard #(.NUM_REGS(32), .REG_ID_W(5), .MAX_INFLIGHT(3)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .wb_write_en(wb_write_en), .wb_write_id(wb_write_id),
      .kill_en(kill_en), .kill_id(kill_id),
      .stall(stall), .issue(issue), .busy_mask(busy_mask), .sb_error(sb_error)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld);
      id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_is_load = ld;
      #1;
   endtask

   task automatic wb(input logic en, input logic [4:0] id);
      wb_write_en = en; wb_write_id = id;
   endtask

   initial begin
      reset_n = 1'b0;
      wb(1'b0, 5'd0);
      kill_en = 1'b0; kill_id = 5'd0;
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      repeat (2) tick();
      chk("rst_issue", {31'd0, issue}, 32'd1);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_busy", busy_mask, 32'd0);
      chk("rst_err", {31'd0, sb_error}, 32'd0);

      // Writer of x5 issues on the first edge after reset release
      reset_n = 1'b1;
      #1;
      chk("x5_issue", {31'd0, issue}, 32'd1);
      tick();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("x5_busy", busy_mask, 32'h20);
      wb(1'b1, 5'd5);
      tick();
      wb(1'b0, 5'd0);
      chk("x5_clear", busy_mask, 32'd0);
      chk("x5_err", {31'd0, sb_error}, 32'd0);

`ifdef FORWARDING_EN
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
      chk("ld3_issue", {31'd0, issue}, 32'd1);
      tick();
      drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("ld3_use_stall", {31'd0, stall}, 32'd1);
      tick();
      chk("ld3_use_go", {31'd0, issue}, 32'd1);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      chk("alu3_issue", {31'd0, issue}, 32'd1);
      tick();
      drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("alu3_use_nostall", {31'd0, stall}, 32'd0);
      tick();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      wb(1'b1, 5'd3);
      repeat (2) tick();
      wb(1'b0, 5'd0);
      chk("x3_drain", busy_mask, 32'd0);
`else
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("raw7_stall_a", {31'd0, stall}, 32'd1);
      chk("raw7_noissue", {31'd0, issue}, 32'd0);
      tick();
      chk("raw7_stall_b", {31'd0, stall}, 32'd1);
      wb(1'b1, 5'd7);
      #1;
      chk("raw7_no_bypass", {31'd0, stall}, 32'd1);
      tick();
      wb(1'b0, 5'd0);
      chk("raw7_release", {31'd0, issue}, 32'd1);
      drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("raw7_rs2_free", {31'd0, stall}, 32'd0);
      tick();
`endif

      // WAW: three writers of x9 fill the slot, a fourth must wait
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      repeat (3) tick();
      chk("waw_busy", busy_mask, 32'h200);
      chk("waw_stall", {31'd0, stall}, 32'd1);
      chk("waw_noissue", {31'd0, issue}, 32'd0);
      wb(1'b1, 5'd9); kill_en = 1'b1; kill_id = 5'd9;
      #1;
      chk("waw_still", {31'd0, stall}, 32'd1);
      tick();
      wb(1'b0, 5'd0); kill_en = 1'b0; kill_id = 5'd0;
      chk("waw_go", {31'd0, issue}, 32'd1);
      tick();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      wb(1'b1, 5'd9);
      tick();
      chk("waw_one_left", busy_mask, 32'h200);
      tick();
      wb(1'b0, 5'd0);
      chk("waw_drain", busy_mask, 32'd0);
      chk("waw_err", {31'd0, sb_error}, 32'd0);

      // x0 is never tracked, never stalls, and writeback to it is ignored
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
      repeat (4) tick();
      chk("x0_stall", {31'd0, stall}, 32'd0);
      chk("x0_busy", busy_mask, 32'd0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      wb(1'b1, 5'd0);
      tick();
      chk("x0_wb_err", {31'd0, sb_error}, 32'd0);
      wb(1'b1, 5'd4);
      tick();
      wb(1'b0, 5'd0);
      chk("uf_err", {31'd0, sb_error}, 32'd1);
      chk("uf_busy", busy_mask, 32'd0);
      repeat (3) tick();
      chk("uf_sticky", {31'd0, sb_error}, 32'd1);

      // Async reset mid-cycle with x2 busy
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("x2_busy", busy_mask, 32'h4);
`ifndef FORWARDING_EN
      chk("x2_stall", {31'd0, stall}, 32'd1);
`endif
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", busy_mask, 32'd0);
      chk("arst_stall", {31'd0, stall}, 32'd0);
      chk("arst_issue", {31'd0, issue}, 32'd1);
      chk("arst_err", {31'd0, sb_error}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
